// File: rtl/cpu_irq_receiver.sv
// CPU-side receiver for the fabric IRQ lines: synchronise, optionally filter,
// latch edge/level events into pending bits and present one prioritised
// request to the CPU with a req/ack handshake.
// Optional build macro: CPU_IRQ_GLITCH_FILTER_EN adds a per-line stability
// filter (FILTER_CYCLES consecutive cycles) after the synchroniser.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no request outstanding; arbitrate over pending & mask
// ST_REQ   | request held to CPU, id frozen until the matching ack
module cpu_irq_receiver #(
    parameter int NUM_IRQ       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               UserCLK,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [NUM_IRQ-1:0] irq_edge_mode,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               irq_req_o,
    output logic [1:0]         irq_id_o,
    input  logic               irq_ack_i,
    input  logic [1:0]         irq_ack_id_i,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    localparam int ID_W = 2;

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
        $error("cpu_irq_receiver: SYNC_STAGES must be >=2 and FILTER_CYCLES >=1");
    end

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] filt;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] ev;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    lowest;
    logic               ack_ok;
    state_t             state_q, state_d;

    // Synchroniser chain; the last stage is the first one safe to use.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef CPU_IRQ_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [NUM_IRQ-1:0][CNT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [NUM_IRQ-1:0]            filt_q, filt_d;

    // Count consecutive disagreements; adopt the new level on the last one.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (sync_s[i] != filt_q[i]) begin
                if (flt_cnt_q[i] == CNT_W'(FILTER_CYCLES - 1)) begin
                    filt_d[i] = sync_s[i];
                end else begin
                    flt_cnt_d[i] = flt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            filt_q    <= '0;
            flt_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_s;
`endif

    assign ev     = (irq_edge_mode & filt & ~prev_q) | (~irq_edge_mode & filt);
    assign active = pend_q & irq_mask;

    // Priority pick (index 0 highest), ack qualification and next state.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        clr     = '0;
        lowest  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                lowest = i[ID_W-1:0];
            end
        end
        ack_ok = (state_q == ST_REQ) && irq_ack_i && (irq_ack_id_i == id_q);
        if (ack_ok) begin
            clr[id_q] = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (|active) begin
                    id_d    = lowest;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_ok) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A fresh event in the clearing cycle keeps the bit set.
        pend_d = ev | (pend_q & ~clr);
    end

    // Edge history, pending bits and handshake registers.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            prev_q  <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            state_q <= ST_IDLE;
        end else begin
            prev_q  <= filt;
            pend_q  <= pend_d;
            req_q   <= req_d;
            id_q    <= id_d;
            state_q <= state_d;
        end
    end

    assign irq_req_o     = req_q;
    assign irq_id_o      = id_q;
    assign irq_pending_o = pend_q;

endmodule

// File: tb/tb_cpu_irq_receiver.sv
// Bench for cpu_irq_receiver: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_cpu_irq_receiver;

    localparam int SYNC = 2;
`ifdef CPU_IRQ_GLITCH_FILTER_EN
    localparam int FC  = 4;
    localparam int LAT = 3 + FC;
`else
    localparam int FC  = 0;
    localparam int LAT = 3;
`endif

    logic       UserCLK = 1'b0;
    logic       resetn  = 1'b0;
    logic [3:0] irq_raw = 4'h0;
    logic [3:0] edge_mode = 4'hF;
    logic [3:0] mask = 4'hF;
    logic       ack = 1'b0;
    logic [1:0] ack_id = 2'd0;
    logic       irq_req_o;
    logic [1:0] irq_id_o;
    logic [3:0] irq_pending_o;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    cpu_irq_receiver #(.NUM_IRQ(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(4)) dut (
        .UserCLK      (UserCLK),
        .resetn       (resetn),
        .IRQ          (irq_raw),
        .irq_edge_mode(edge_mode),
        .irq_mask     (mask),
        .irq_req_o    (irq_req_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id),
        .irq_pending_o(irq_pending_o)
    );

    always #5 UserCLK = ~UserCLK;

    // ---------------- behavioural model ----------------
    // raw_q[j] holds the IRQ sample taken j+1 edges ago; the value the
    // design acts on at an edge is the sample from SYNC edges earlier.
    logic [3:0] raw_q[$];
    logic [3:0] m_prevf = 4'h0;
    logic [3:0] m_pend  = 4'h0;
    logic       m_req   = 1'b0;
    logic [1:0] m_id    = 2'd0;
    logic [3:0] s_b, fb, ev, clr, act;
    logic       ack_ok;
`ifdef CPU_IRQ_GLITCH_FILTER_EN
    logic [3:0] sh_q[$];
    logic [3:0] m_f = 4'h0;
    logic [3:0] nf;
    logic       all_d;
`endif

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !found) begin
                r = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    initial forever begin
        @(posedge UserCLK or negedge resetn);
        if (!resetn) begin
            raw_q.delete();
            m_prevf = 4'h0; m_pend = 4'h0; m_req = 1'b0; m_id = 2'd0;
`ifdef CPU_IRQ_GLITCH_FILTER_EN
            sh_q.delete();
            m_f = 4'h0;
`endif
        end else begin
            s_b = (raw_q.size() >= SYNC) ? raw_q[SYNC-1] : 4'h0;
            raw_q.push_front(irq_raw);
            if (raw_q.size() > SYNC + 1) void'(raw_q.pop_back());
`ifdef CPU_IRQ_GLITCH_FILTER_EN
            // The filtered level flips once the last FC samples all disagree with it.
            fb = m_f;
            sh_q.push_front(s_b);
            if (sh_q.size() > FC) void'(sh_q.pop_back());
            nf = m_f;
            for (int i = 0; i < 4; i++) begin
                all_d = (sh_q.size() >= FC);
                for (int j = 0; j < FC; j++)
                    if (j < sh_q.size() && sh_q[j][i] == m_f[i]) all_d = 1'b0;
                if (all_d) nf[i] = s_b[i];
            end
            m_f = nf;
`else
            fb = s_b;
`endif
            ev      = (edge_mode & fb & ~m_prevf) | (~edge_mode & fb);
            m_prevf = fb;
            ack_ok  = m_req && ack && (ack_id == m_id);
            clr     = ack_ok ? (4'h1 << m_id) : 4'h0;
            act     = m_pend & mask;
            if (!m_req) begin
                if (act != 4'h0) begin
                    m_id  = lowest_idx(act);
                    m_req = 1'b1;
                end
            end else if (ack_ok) begin
                m_req = 1'b0;
            end
            m_pend = ev | (m_pend & ~clr);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge UserCLK) begin
        if (cmp_en) begin
            total++;
            if (irq_req_o !== m_req) begin
                bad++;
                $display("FAIL model_req t=%0t got=%0b exp=%0b", $time, irq_req_o, m_req);
            end
            total++;
            if (irq_pending_o !== m_pend) begin
                bad++;
                $display("FAIL model_pend t=%0t got=%0h exp=%0h", $time, irq_pending_o, m_pend);
            end
            if (m_req) begin
                total++;
                if (irq_id_o !== m_id) begin
                    bad++;
                    $display("FAIL model_id t=%0t got=%0d exp=%0d", $time, irq_id_o, m_id);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic wait_req(input string nm, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!irq_req_o && n < budget);
        if (!irq_req_o) begin
            total++;
            bad++;
            $display("FAIL %s_timeout t=%0t got=no_req exp=req", nm, $time);
        end
    endtask

    task automatic do_ack(input logic [1:0] id);
        ack = 1'b1;
        ack_id = id;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        irq_raw = 4'h0; ack = 1'b0; ack_id = 2'd0;
        edge_mode = 4'hF; mask = 4'hF;
        ticks(2);
        resetn = 1'b1;
        tick();
    endtask

    int n;

    initial begin
        // Reset held while the lines toggle.
        tick();
        cmp_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            irq_raw = (k % 2 == 0) ? 4'hF : 4'h0;
            tick();
            chk("rst_req", {7'd0, irq_req_o}, 8'h00);
            chk("rst_pend", {4'd0, irq_pending_o}, 8'h00);
        end
        do_reset();

        // Edge on line 2: latency and ack.
        irq_raw = 4'b0100;
        wait_req("edge2", 30, n);
        chk("edge2_latency", 8'(n), 8'(LAT + 1));
        chk("edge2_id", {6'd0, irq_id_o}, 8'h02);
        do_ack(2'd2);
        chk("edge2_ack_pend", {4'd0, irq_pending_o}, 8'h00);
        chk("edge2_ack_req", {7'd0, irq_req_o}, 8'h00);
        irq_raw = 4'h0;
        ticks(LAT + 2);

        // Frozen id while a higher-priority line arrives.
        irq_raw = 4'b1000;
        wait_req("prio3", 30, n);
        chk("prio_id3", {6'd0, irq_id_o}, 8'h03);
        irq_raw = 4'b1001;
        ticks(LAT + 1);
        chk("prio_frozen_req", {7'd0, irq_req_o}, 8'h01);
        chk("prio_frozen_id", {6'd0, irq_id_o}, 8'h03);
        chk("prio_pend", {4'd0, irq_pending_o}, 8'h09);
        do_ack(2'd3);
        chk("prio_gap_req", {7'd0, irq_req_o}, 8'h00);
        chk("prio_gap_pend", {4'd0, irq_pending_o}, 8'h01);
        tick();
        chk("prio_next_req", {7'd0, irq_req_o}, 8'h01);
        chk("prio_next_id", {6'd0, irq_id_o}, 8'h00);
        do_ack(2'd0);
        chk("prio_done_pend", {4'd0, irq_pending_o}, 8'h00);

        // Level-triggered line 1.
        do_reset();
        edge_mode = 4'h0;
        irq_raw = 4'b0010;
        wait_req("lvl1", 30, n);
        chk("lvl_id", {6'd0, irq_id_o}, 8'h01);
        do_ack(2'd1);
        chk("lvl_ack_req", {7'd0, irq_req_o}, 8'h00);
        chk("lvl_ack_pend", {4'd0, irq_pending_o}, 8'h02);
        tick();
        chk("lvl_reassert", {7'd0, irq_req_o}, 8'h01);
        irq_raw = 4'h0;
        ticks(3 + FC);
        do_ack(2'd1);
        chk("lvl_low_pend", {4'd0, irq_pending_o}, 8'h00);
        chk("lvl_low_req", {7'd0, irq_req_o}, 8'h00);
        ticks(3);
        chk("lvl_stays_low", {7'd0, irq_req_o}, 8'h00);

        // Masking, mismatched ack, set-wins-over-clear.
        do_reset();
        mask = 4'hE;
        irq_raw = 4'b0001;
        ticks(LAT + 1);
        chk("mask_pend", {4'd0, irq_pending_o}, 8'h01);
        chk("mask_noreq", {7'd0, irq_req_o}, 8'h00);
        mask = 4'hF;
        tick();
        chk("unmask_req", {7'd0, irq_req_o}, 8'h01);
        chk("unmask_id", {6'd0, irq_id_o}, 8'h00);
        do_ack(2'd1);
        chk("badack_req", {7'd0, irq_req_o}, 8'h01);
        chk("badack_pend", {4'd0, irq_pending_o}, 8'h01);
        irq_raw = 4'h0;
        ticks(LAT + 1);
        irq_raw = 4'b0001;
        ticks(LAT - 1);
        do_ack(2'd0);
        chk("setwin_pend", {4'd0, irq_pending_o}, 8'h01);
        chk("setwin_req", {7'd0, irq_req_o}, 8'h00);
        tick();
        chk("setwin_rereq", {7'd0, irq_req_o}, 8'h01);
        do_ack(2'd0);
        chk("setwin_clear", {4'd0, irq_pending_o}, 8'h00);

        // Reset in the middle of a request drops it at once.
        irq_raw = 4'h0;
        ticks(LAT + 1);
        irq_raw = 4'b0100;
        wait_req("midrst", 30, n);
        resetn = 1'b0;
        #1;
        chk("midrst_req", {7'd0, irq_req_o}, 8'h00);
        chk("midrst_pend", {4'd0, irq_pending_o}, 8'h00);
        do_reset();

`ifdef CPU_IRQ_GLITCH_FILTER_EN
        // Short pulse dropped, long pulse accepted.
        irq_raw = 4'b0001;
        ticks(3);
        irq_raw = 4'h0;
        ticks(12);
        chk("flt_short_pend", {4'd0, irq_pending_o}, 8'h00);
        irq_raw = 4'b0001;
        n = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6) irq_raw = 4'h0;
            if (irq_req_o && n == 0) n = k;
        end
        chk("flt_long_latency", 8'(n), 8'(LAT + 1));
        do_reset();
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                resetn = 1'b0;
            end else begin
                resetn = 1'b1;
            end
            r = int'($urandom_range(0, 99));
            if (r < 12) irq_raw = 4'($urandom);
            else if (r < 22) irq_raw[$urandom_range(0, 3)] = ~irq_raw[$urandom_range(0, 3)];
            if ($urandom_range(0, 99) < 3) mask = 4'($urandom);
            if ($urandom_range(0, 99) < 2) edge_mode = 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (m_req && r < 35) begin
                ack = 1'b1;
                ack_id = ($urandom_range(0, 99) < 80) ? m_id : 2'($urandom);
            end else if (r > 95) begin
                ack = 1'b1;
                ack_id = 2'($urandom);
            end else begin
                ack = 1'b0;
            end
            tick();
        end
        ack = 1'b0;
        resetn = 1'b1;
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
